// File: rtl/outbus_pkg.sv
// outbus_pkg: register offsets and channel decode shared by the output port bank
package outbus_pkg;
  localparam logic [2:0] OFS_DATA  = 3'd0;
  localparam logic [2:0] OFS_SET   = 3'd1;
  localparam logic [2:0] OFS_CLR   = 3'd2;
  localparam logic [2:0] OFS_TGL   = 3'd3;
  localparam logic [2:0] OFS_PLEN  = 3'd4;
  localparam logic [2:0] OFS_PULSE = 3'd5;
  localparam int CH_STRIDE = 8;
  function automatic logic ch_sel(input logic [7:0] addr, input logic [7:0] base, input int c);
    return addr[7:3] == 5'(int'(base[7:3]) + c);
  endfunction
endpackage

// File: rtl/output_port_channel.sv
// output_port_channel: one pin register with set/clr/toggle and self-clearing pulses
module output_port_channel
  import outbus_pkg::*;
#(
  parameter int PIN_WIDTH = 8,
  parameter int CNT_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [2:0]           ofs,
  input  logic [PIN_WIDTH-1:0] d,
  input  logic [CNT_W-1:0]     plen_d,
  output logic [PIN_WIDTH-1:0] pins,
  output logic                 busy
);
  logic [PIN_WIDTH-1:0] mask, pins_w;
  logic [CNT_W-1:0] cnt, plen;
  logic data_wr, pulse_wr, plen_wr, expire;
  always_comb begin
    data_wr  = we && ofs == OFS_DATA;
    pulse_wr = we && ofs == OFS_PULSE && d != '0;
    plen_wr  = we && ofs == OFS_PLEN;
    expire   = busy && cnt == CNT_W'(1);
    pins_w   = !we ? pins :
               ofs == OFS_SET ? pins | d :
               ofs == OFS_CLR ? pins & ~d :
               ofs == OFS_TGL ? pins ^ d : pins;
  end
  // priority: DATA cancels, PULSE retriggers, otherwise write then expiry clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pins <= '0;
      mask <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      plen <= CNT_W'(1);
    end else begin
      if (plen_wr) plen <= plen_d == '0 ? CNT_W'(1) : plen_d;
      if (data_wr) begin
        pins <= d;
        mask <= '0;
        cnt  <= '0;
        busy <= 1'b0;
      end else if (pulse_wr) begin
        pins <= pins | d;
        mask <= mask | d;
        cnt  <= plen;
        busy <= 1'b1;
      end else if (expire) begin
        pins <= pins_w & ~mask;
        mask <= '0;
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        pins <= pins_w;
        if (busy) cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/output_port_bank.sv
// output_port_bank: NUM_CH output registers decoded from the 8-bit-address OUTBUS
module output_port_bank
  import outbus_pkg::*;
#(
  parameter int PIN_WIDTH = 8,
  parameter int NUM_CH = 4,
  parameter int BUS_W = 16,
  parameter int CNT_W = 12,
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  OUTBUS_ADDR,
  input  logic [BUS_W-1:0]            OUTBUS_DATA,
  input  logic                        OUTBUS_WE,
  output logic [NUM_CH*PIN_WIDTH-1:0] OUTPUT_PIN,
  output logic [NUM_CH-1:0]           PULSE_BUSY
);
  logic unused_data;
  assign unused_data = ^OUTBUS_DATA;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic ch_we;
    assign ch_we = OUTBUS_WE && ch_sel(OUTBUS_ADDR, BASE_ADDR, c);
    output_port_channel #(.PIN_WIDTH(PIN_WIDTH), .CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .we     (ch_we),
      .ofs    (OUTBUS_ADDR[2:0]),
      .d      (OUTBUS_DATA[PIN_WIDTH-1:0]),
      .plen_d (OUTBUS_DATA[CNT_W-1:0]),
      .pins   (OUTPUT_PIN[c*PIN_WIDTH +: PIN_WIDTH]),
      .busy   (PULSE_BUSY[c])
    );
  end
endmodule

// File: tb/tb_output_port_bank.sv
// tb_output_port_bank: timestamp-based reference model feeding an expected-value queue
module tb_output_port_bank;
  logic clk = 0, reset = 0, we = 0;
  logic [7:0] addr = 0;
  logic [15:0] data = 0;
  logic [31:0] pin;
  logic [3:0] busy;
  logic [35:0] q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [7:0] m_pins[4], m_mask[4];
  int m_exp[4], m_plen[4];

  output_port_bank dut (
    .clk(clk), .reset(reset), .OUTBUS_ADDR(addr), .OUTBUS_DATA(data),
    .OUTBUS_WE(we), .OUTPUT_PIN(pin), .PULSE_BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_pins[c] = 0; m_mask[c] = 0; m_exp[c] = 0; m_plen[c] = 1;
    end
  endtask

  function automatic logic [35:0] expected();
    logic [35:0] e;
    for (int c = 0; c < 4; c++) begin
      e[4 + c*8 +: 8] = m_pins[c];
      e[c] = m_exp[c] != 0;
    end
    return e;
  endfunction

  // expiry is tracked as the absolute edge number at which pulsed bits drop
  task automatic step(input logic w, input logic [7:0] a, input logic [15:0] dt);
    @(negedge clk);
    we = w; addr = a; data = dt;
    cyc++;
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        logic sel;
        logic [7:0] d;
        sel = w && a[7:3] == 5'(2 + c);
        d = dt[7:0];
        if (sel && a[2:0] == 0) begin
          m_pins[c] = d; m_mask[c] = 0; m_exp[c] = 0;
        end else if (sel && a[2:0] == 5 && d != 0) begin
          m_pins[c] |= d; m_mask[c] |= d; m_exp[c] = cyc + m_plen[c];
        end else begin
          if (sel && a[2:0] == 1) m_pins[c] |= d;
          if (sel && a[2:0] == 2) m_pins[c] &= ~d;
          if (sel && a[2:0] == 3) m_pins[c] ^= d;
          if (m_exp[c] == cyc) begin
            m_pins[c] &= ~m_mask[c]; m_mask[c] = 0; m_exp[c] = 0;
          end
        end
        if (sel && a[2:0] == 4) m_plen[c] = dt[11:0] == 0 ? 1 : int'(dt[11:0]);
      end
    end
    q.push_back(expected());
    @(posedge clk);
    #1;
    check($sformatf("cyc%0d", cyc), {pin, busy}, q.pop_front());
    we = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 8'h00, 16'h0000);
  endtask

  initial begin
    model_reset();
    idle(2);
    check("reset_init", {pin, busy}, 36'h0);
    @(negedge clk); reset = 1;
    step(1, 8'h10, 16'h00FF);
    step(1, 8'h24, 16'd20);
    step(1, 8'h25, 16'h0001);
    idle(2);
    check("pre_reset_busy", 36'(busy), 36'h4);
    #2 reset = 0;
    #1 check("async_reset", {pin, busy}, 36'h0);
    model_reset();
    idle(2);
    @(negedge clk); reset = 1;
    idle(3);
    check("no_residual", {pin, busy}, 36'h0);
    step(1, 8'h10, 16'h003C);
    check("ch0_data", {pin, busy}, {32'h0000_003C, 4'h0});
    step(1, 8'h18, 16'h00F0);
    step(1, 8'h19, 16'h000F);
    step(1, 8'h1A, 16'h0081);
    check("ch1_clr", 36'(pin[15:8]), 36'h7E);
    step(1, 8'h1B, 16'h00FF);
    check("ch1_tgl", 36'(pin[15:8]), 36'h81);
    step(1, 8'h24, 16'd5);
    step(1, 8'h25, 16'h0001);
    idle(4);
    check("ch2_plen5_last", {28'h0, pin[16], busy}, {28'h0, 1'b1, 4'h4});
    idle(2);
    check("ch2_plen5_done", {28'h0, pin[16], busy}, 36'h0);
    step(1, 8'h24, 16'd0);
    step(1, 8'h25, 16'h0001);
    idle(2);
    step(1, 8'h2C, 16'd10);
    step(1, 8'h2D, 16'h0001);
    idle(3);
    step(1, 8'h2D, 16'h0002);
    idle(9);
    check("ch3_retrig_hold", 36'(pin[31:24]), 36'h03);
    idle(2);
    check("ch3_retrig_clear", {pin[31:24], busy}, 36'h0);
    step(1, 8'h2D, 16'h0001);
    idle(2);
    step(1, 8'h28, 16'h0080);
    idle(12);
    check("ch3_cancel", {pin[31:24], busy}, {8'h80, 4'h0});
    step(1, 8'h24, 16'd3);
    step(1, 8'h25, 16'h0001);
    idle(2);
    step(1, 8'h21, 16'h0001);
    check("set_on_expiry", {28'h0, pin[16], busy[2]}, 36'h0);
    step(1, 8'h25, 16'h0001);
    idle(2);
    step(1, 8'h25, 16'h0001);
    check("pulse_on_expiry", {28'h0, pin[16], busy[2]}, 36'h3);
    idle(4);
    step(1, 8'h16, 16'h00FF);
    step(1, 8'h17, 16'h00FF);
    step(1, 8'h30, 16'h00FF);
    step(1, 8'h25, 16'h0100);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/output_port_bank.md
Name: output_port_bank

Overview:
- Multi-channel successor to the single-register output pin peripheral on the 8-bit-address OUTBUS.
- Provides NUM_CH independent output registers of PIN_WIDTH bits each.
- Each register supports direct write, bitwise set/clear/toggle, and self-timed pulses that auto-clear after a programmable number of cycles.
- Drives board-level pins (LEDs, strobes, enables) from the processor's output bus.

Parameters:
- PIN_WIDTH, 8: bits per channel.
- NUM_CH, 4: number of channels.
- BUS_W, 16: OUTBUS_DATA width; requires PIN_WIDTH <= BUS_W and CNT_W <= BUS_W.
- CNT_W, 12: pulse-length counter width.
- BASE_ADDR, 8'h10: first bus address. Must be 8-aligned; BASE_ADDR + 8*NUM_CH <= 256.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- OUTBUS_ADDR  input  8  bus address.
- OUTBUS_DATA  input  BUS_W  bus write data.
- OUTBUS_WE  input  1  write strobe, one write per asserted cycle.
- OUTPUT_PIN  output  NUM_CH*PIN_WIDTH  channel c occupies bits [c*PIN_WIDTH +: PIN_WIDTH].
- PULSE_BUSY  output  NUM_CH  bit c high while channel c has a pulse timer running.

Behaviour:
- Reset: asynchronous on reset low. OUTPUT_PIN=0, PULSE_BUSY=0, all pulse masks=0, all counters=0, all PLEN registers=1. Release is synchronous to clk.
- Decode: channel c is selected when OUTBUS_WE=1 and OUTBUS_ADDR[7:3] == BASE_ADDR[7:3]+c. Offset is OUTBUS_ADDR[2:0]. Unselected addresses are ignored.
- D = OUTBUS_DATA[PIN_WIDTH-1:0].
- Offset 0 DATA: pins <= D. Cancels any active pulse (mask<=0, counter<=0, BUSY<=0).
- Offset 1 SET: pins <= pins | D.
- Offset 2 CLR: pins <= pins & ~D.
- Offset 3 TGL: pins <= pins ^ D.
- Offset 4 PLEN: PLEN <= OUTBUS_DATA[CNT_W-1:0]. A written value of 0 is stored as 1. Does not affect a pulse already running.
- Offset 5 PULSE: pins <= pins | D; mask <= mask | D; counter <= PLEN; BUSY <= 1. This is a retrigger: the counter restarts and mask bits accumulate. If D=0, the write is ignored entirely.
- Offsets 6, 7: reserved, writes ignored.
- Latency: every write takes effect on the clk edge that samples WE; outputs are registered, no combinational path from bus to pins.
- Pulse timing:
  - While BUSY, the counter decrements each edge.
  - On the edge where the counter == 1: pins <= pins & ~mask, mask <= 0, counter <= 0, BUSY <= 0.
  - Net effect: pulsed bits are high for exactly PLEN cycles; BUSY covers the same cycles.
- Expiry coinciding with a write to the same channel:
  - PULSE write: the retrigger wins. No clear occurs, the counter reloads, and the mask becomes old|D.
  - DATA write: the DATA value wins, and the pulse is cancelled.
  - SET/CLR/TGL: the write is applied first, then mask bits are cleared. A SET of a masked bit on the expiry edge therefore ends low.
- SET/CLR/TGL during an active pulse: applied immediately; mask and counter are unchanged; masked bits still clear at expiry.
- Channels are fully independent; a write to one channel never changes another.
- Reset mid-pulse: everything returns to reset values immediately; no residual pulse after release.

Decomposition:
- Package outbus_pkg holds:
  - offset constants OFS_DATA=0, OFS_SET=1, OFS_CLR=2, OFS_TGL=3, OFS_PLEN=4, OFS_PULSE=5;
  - CH_STRIDE=8;
  - the channel-select function (addr, base, c).
- Sub-module output_port_channel (PIN_WIDTH, CNT_W) contains one channel's pin register, mask, PLEN, counter and busy flag, and takes a decoded write-enable plus offset.
- output_port_bank does the address decode and a generate loop over NUM_CH instances.

Test Plan:
- Reset low mid-operation with pins=8'hFF and a pulse running -> OUTPUT_PIN=0 and PULSE_BUSY=0 immediately (asynchronous). After release, a DATA write of 8'h3C to ch0 at addr 8'h10 -> ch0 pins=8'h3C next edge; other channels stay 0.
- ch1 at 8'h18: DATA 8'hF0, SET 8'h0F, CLR 8'h81, TGL 8'hFF -> pins sequence F0, FF, 7E, 81, one edge per write.
- ch2 at 8'h20: PLEN=5, then PULSE 8'h01 -> bit0 high and BUSY[2]=1 for exactly 5 cycles, then both low. PLEN=0 then PULSE -> high for 1 cycle.
- Retrigger: ch3 PLEN=10, PULSE 8'h01; after 4 cycles, PULSE 8'h02 -> bits 0 and 1 both clear together 10 cycles after the second write. DATA 8'h80 issued mid-pulse -> pins=8'h80, BUSY low, no later clear.
- Expiry collision: issue SET 8'h01 on ch2 on the expiry edge of a pulse with mask 8'h01 -> bit0 ends low. Issue PULSE on the expiry edge instead -> bit0 stays high and the pulse restarts.
- Writes to addr 8'h16, 8'h17 and to 8'h30 (beyond NUM_CH=4) -> no change on any OUTPUT_PIN or PULSE_BUSY bit.
